// File: rtl/access_slot_scheduler.sv
// access_slot_scheduler
//   Derives SLOTS evenly spaced access slots per video frame from the beam
//   position. Each slot is arbitrated round-robin among CHANNELS requesters.
//   The winner receives a one-cycle chip-enable.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   shpos     horizontal beam position
//   svpos     vertical beam position
//   req       per-channel request (pulse or level)
//   slot_ce   one-cycle pulse per slot, requested or not
//   slot_idx  index of the slot just fired (valid with slot_ce)
//   ce        one-hot grant pulse coincident with slot_ce
//   pending   latched, not-yet-served requests
//   miss_cnt  saturating count of contended slots
//
// Optional feature: define ACCESS_SLOT_MISS_EN to build the contention
// counter. Without that macro, miss_cnt is tied to zero.
module access_slot_scheduler #(
  parameter int HPOS_W    = 10,
  parameter int VPOS_W    = 10,
  parameter int TRIGGER_H = 300,
  parameter int VSTRIDE   = 131,
  parameter int SLOTS     = 4,
  parameter int CHANNELS  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [HPOS_W-1:0]   shpos,
  input  logic [VPOS_W-1:0]   svpos,
  input  logic [CHANNELS-1:0] req,
  output logic                slot_ce,
  output logic [3:0]          slot_idx,
  output logic [CHANNELS-1:0] ce,
  output logic [CHANNELS-1:0] pending,
  output logic [7:0]          miss_cnt
);

  localparam int                RR_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [HPOS_W-1:0] TRIG  = HPOS_W'(TRIGGER_H);
  localparam logic [VPOS_W-1:0] VSTEP = VPOS_W'(VSTRIDE);
  localparam logic [4:0]        NSLOT = 5'(SLOTS);

  // armed_q is cleared by reset. It keeps a reset released mid-frame from
  // firing slots before the next frame resync.
  logic                armed_q, armed_d;
  logic [VPOS_W-1:0]   next_v_q, next_v_d;
  logic [4:0]          slot_cnt_q, slot_cnt_d;
  logic [RR_W-1:0]     rr_q, rr_d;
  logic [CHANNELS-1:0] pend_q, pend_d;
  logic [CHANNELS-1:0] ce_q, ce_d;
  logic                slot_ce_q, slot_ce_d;
  logic [3:0]          slot_idx_q, slot_idx_d;
  logic [CHANNELS-1:0] eff, grant;
  logic                resync, slot_evt;

  assign resync   = (shpos == '0) && (svpos == '0);
  assign slot_evt = !resync && armed_q && (shpos == TRIG) &&
                    (svpos == next_v_q) && (slot_cnt_q < NSLOT);
  // A request arriving in the same cycle as the slot can still win it.
  assign eff      = pend_q | req;

  // Round-robin search. It starts at rr_q and wraps modulo CHANNELS.
  always_comb begin
    int  k;
    logic found;
    grant = '0;
    rr_d  = rr_q;
    found = 1'b0;
    k     = 0;
    if (slot_evt) begin
      for (int i = 0; i < CHANNELS; i++) begin
        k = (int'(rr_q) + i) % CHANNELS;
        if (!found && eff[k]) begin
          found    = 1'b1;
          grant[k] = 1'b1;
          rr_d     = RR_W'((k + 1) % CHANNELS);
        end
      end
    end
  end

  always_comb begin
    armed_d    = armed_q;
    next_v_d   = next_v_q;
    slot_cnt_d = slot_cnt_q;
    if (resync) begin
      armed_d    = 1'b1;
      next_v_d   = '0;
      slot_cnt_d = '0;
    end else if (slot_evt) begin
      next_v_d   = next_v_q + VSTEP;
      slot_cnt_d = slot_cnt_q + 5'd1;
    end
    slot_ce_d  = slot_evt;
    slot_idx_d = slot_evt ? slot_cnt_q[3:0] : slot_idx_q;
    ce_d       = grant;
    pend_d     = eff & ~grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q    <= 1'b0;
      next_v_q   <= '0;
      slot_cnt_q <= '0;
      rr_q       <= '0;
      pend_q     <= '0;
      ce_q       <= '0;
      slot_ce_q  <= 1'b0;
      slot_idx_q <= '0;
    end else begin
      armed_q    <= armed_d;
      next_v_q   <= next_v_d;
      slot_cnt_q <= slot_cnt_d;
      rr_q       <= rr_d;
      pend_q     <= pend_d;
      ce_q       <= ce_d;
      slot_ce_q  <= slot_ce_d;
      slot_idx_q <= slot_idx_d;
    end
  end

`ifdef ACCESS_SLOT_MISS_EN
  logic [7:0] miss_q, miss_d;

  always_comb begin
    miss_d = miss_q;
    if (slot_evt && ($countones(eff) > 1) && (miss_q != 8'hFF))
      miss_d = miss_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) miss_q <= '0;
    else        miss_q <= miss_d;
  end

  assign miss_cnt = miss_q;
`else
  assign miss_cnt = '0;
`endif

  assign slot_ce  = slot_ce_q;
  assign slot_idx = slot_idx_q;
  assign ce       = ce_q;
  assign pending  = pend_q;

endmodule

// File: tb/tb_access_slot_scheduler.sv
module tb_access_slot_scheduler;

  localparam int TRIG = 300;
  localparam int VST  = 131;
  localparam int NSL  = 4;
  localparam int NCH  = 4;

  logic       clk, rst_n;
  logic [9:0] shpos, svpos;
  logic [3:0] req;
  logic       slot_ce;
  logic [3:0] slot_idx;
  logic [3:0] ce, pending;
  logic [7:0] miss_cnt;

  logic [1:0] req2, ce2, pending2;
  logic       slot_ce2;
  logic [3:0] slot_idx2;
  logic [7:0] miss_cnt2;

  access_slot_scheduler dut (
    .clk(clk), .rst_n(rst_n), .shpos(shpos), .svpos(svpos), .req(req),
    .slot_ce(slot_ce), .slot_idx(slot_idx), .ce(ce), .pending(pending),
    .miss_cnt(miss_cnt)
  );

  access_slot_scheduler #(
    .HPOS_W(10), .VPOS_W(10), .TRIGGER_H(300), .VSTRIDE(200),
    .SLOTS(2), .CHANNELS(2)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .shpos(shpos), .svpos(svpos), .req(req2),
    .slot_ce(slot_ce2), .slot_idx(slot_idx2), .ce(ce2), .pending(pending2),
    .miss_cnt(miss_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model: slot n of a frame sits on line n*VSTRIDE.
  bit   m_armed;
  int   m_fired, m_rr, m_miss;
  logic [3:0] m_pend, m_ce;
  logic m_slot_ce;
  int   m_slot_idx;

  // Event logs used for the literal checks.
  int ev_n, ev_line[16], ev_idx[16], ev_ce[16];
  int ev2_n, ev2_line[16], ev2_ce[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_fired = 0; m_rr = 0; m_miss = 0;
    m_pend = '0; m_ce = '0; m_slot_ce = 0; m_slot_idx = 0;
  endtask

  task automatic model_step(input int h, input int v, input logic [3:0] r);
    logic [3:0] eff, g;
    bit e;
    eff = m_pend | r;
    g   = '0;
    e   = 0;
    if (h == 0 && v == 0) begin
      m_armed = 1; m_fired = 0;
    end else begin
      e = m_armed && (m_fired < NSL) && (h == TRIG) && (v == (m_fired * VST) % 1024);
    end
    if (e) begin
      for (int i = 0; i < NCH; i++) begin
        if (g == '0 && eff[(m_rr + i) % NCH]) begin
          g[(m_rr + i) % NCH] = 1'b1;
          m_rr = (m_rr + i + 1) % NCH;
        end
      end
`ifdef ACCESS_SLOT_MISS_EN
      if ($countones(eff) > 1 && m_miss < 255) m_miss++;
`endif
      m_slot_idx = m_fired;
      m_fired++;
    end
    m_slot_ce = e;
    m_ce      = g;
    m_pend    = eff & ~g;
  endtask

  // One clock: drive at the falling edge, then update the model at the rising
  // edge, then compare 1 ns later.
  task automatic tick(input int h, input int v, input logic [3:0] r,
                      input logic [1:0] r2, input logic rb);
    shpos = 10'(h); svpos = 10'(v); req = r; req2 = r2; rst_n = rb;
    if (!rb) model_reset();
    @(posedge clk);
    if (rb) model_step(h, v, r);
    #1;
    chk("slot_ce", 32'(slot_ce), 32'(m_slot_ce));
    chk("ce", 32'(ce), 32'(m_ce));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("miss_cnt", 32'(miss_cnt), 32'(m_miss));
    if (m_slot_ce) chk("slot_idx", 32'(slot_idx), 32'(m_slot_idx));
    if (slot_ce && ev_n < 16) begin
      ev_line[ev_n] = v; ev_idx[ev_n] = int'(slot_idx); ev_ce[ev_n] = int'(ce); ev_n++;
    end
    if (slot_ce2 && ev2_n < 16) begin
      ev2_line[ev2_n] = v; ev2_ce[ev2_n] = int'(ce2); ev2_n++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick(0, 0, 4'b0, 2'b0, 1'b0);
    tick(0, 0, 4'b0, 2'b0, 1'b0);
  endtask

  // Full frame of 450 lines. Each line visits shpos 0,299,300,300,301, so a
  // slot position is held for two cycles.
  task automatic frame(input logic [3:0] lvl, input int pulse_line,
                       input logic [3:0] pulse_mask, input logic [1:0] r2,
                       input int rst_lo, input int rst_hi);
    int hs[5] = '{0, 299, 300, 300, 301};
    logic [3:0] r;
    ev_n = 0; ev2_n = 0;
    for (int l = 0; l < 450; l++) begin
      for (int s = 0; s < 5; s++) begin
        r = lvl | ((l == pulse_line && s == 4) ? pulse_mask : 4'b0);
        tick(hs[s], l, r, r2, !(l >= rst_lo && l < rst_hi));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; shpos = '0; svpos = '0; req = '0; req2 = '0;
    ev_n = 0; ev2_n = 0;
    model_reset();
    @(negedge clk);
    do_reset();
    chk("rst slot_ce", 32'(slot_ce), 32'h0);
    chk("rst slot_idx", 32'(slot_idx), 32'h0);
    chk("rst ce", 32'(ce), 32'h0);
    chk("rst pending", 32'(pending), 32'h0);
    chk("rst miss_cnt", 32'(miss_cnt), 32'h0);

    // Idle frame: four slots, no grants.
    frame(4'b0, -1, 4'b0, 2'b0, -1, -1);
    chk("t1 count", 32'(ev_n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1 line", 32'(ev_line[i]), 32'(i * 131));
      chk("t1 idx", 32'(ev_idx[i]), 32'(i));
      chk("t1 ce", 32'(ev_ce[i]), 32'h0);
    end

    // Single request pulse on line 50 is served by slot 1.
    frame(4'b0, 50, 4'b0001, 2'b0, -1, -1);
    chk("t2 slot0 ce", 32'(ev_ce[0]), 32'h0);
    chk("t2 slot1 ce", 32'(ev_ce[1]), 32'h1);
    chk("t2 slot1 idx", 32'(ev_idx[1]), 32'd1);
    chk("t2 pending end", 32'(pending), 32'h0);

    // All channels held high: grant order is ch0..ch3.
    do_reset();
    frame(4'b1111, -1, 4'b0, 2'b0, -1, -1);
    chk("t3 ce0", 32'(ev_ce[0]), 32'h1);
    chk("t3 ce1", 32'(ev_ce[1]), 32'h2);
    chk("t3 ce2", 32'(ev_ce[2]), 32'h4);
    chk("t3 ce3", 32'(ev_ce[3]), 32'h8);
    chk("t3 pending nz", 32'(pending != 0), 32'h1);
`ifdef ACCESS_SLOT_MISS_EN
    chk("t3 miss", 32'(miss_cnt), 32'd4);
`else
    chk("t3 miss", 32'(miss_cnt), 32'd0);
`endif

    // Reset from line 200 to 209 suppresses slots on lines 262 and 393.
    do_reset();
    frame(4'b0101, -1, 4'b0, 2'b0, 200, 210);
    chk("t4 count", 32'(ev_n), 32'd2);
    chk("t4 line1", 32'(ev_line[1]), 32'd131);
    chk("t4 ce1", 32'(ev_ce[1]), 32'h4);
    frame(4'b0101, -1, 4'b0, 2'b0, -1, -1);
    chk("t4 next count", 32'(ev_n), 32'd4);

    // Two-slot, two-channel instance.
    do_reset();
    frame(4'b0, -1, 4'b0, 2'b10, -1, -1);
    chk("t5 count", 32'(ev2_n), 32'd2);
    chk("t5 line0", 32'(ev2_line[0]), 32'd0);
    chk("t5 line1", 32'(ev2_line[1]), 32'd200);
    chk("t5 ce0", 32'(ev2_ce[0]), 32'h2);
    chk("t5 ce1", 32'(ev2_ce[1]), 32'h2);

    // 320 contended slots using sparse frames.
    do_reset();
    for (int f = 0; f < 80; f++) begin
      tick(0, 0, 4'b1111, 2'b0, 1'b1);
      for (int s = 0; s < 4; s++) tick(300, s * 131, 4'b1111, 2'b0, 1'b1);
      tick(301, 393, 4'b1111, 2'b0, 1'b1);
    end
`ifdef ACCESS_SLOT_MISS_EN
    chk("sat miss", 32'(miss_cnt), 32'd255);
`else
    chk("sat miss", 32'(miss_cnt), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
